encoder_input_loader: RTL
=========================

Name: encoder_input_loader

Overview:
- Serial-to-parallel front end for the fixed-point dense encoder stage.
- Accepts one BITSIZE-bit fixed-point sample per handshake on a valid/ready stream and assembles N_input samples into a packed vector.
- Presents the vector to the encoder's x input, held stable with x_valid until the downstream controller accepts it.
- Checks frame length against s_last and discards malformed frames.

Parameters:
- N_input, 9, samples per vector (must be ≥2).
- BITSIZE, 32, width of one fixed-point sample; the loader is format-agnostic and does no arithmetic on the data.
- CNT_W, $clog2(N_input)+1, width of the word counter and the word_cnt output.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  BITSIZE  signed input sample.
- s_valid  in  1  s_data/s_last valid.
- s_last  in  1  marks the final sample of a frame.
- s_ready  out  1  loader can accept a sample (registered).
- x  out  N_input*BITSIZE  packed vector; sample i at bits [i*BITSIZE +: BITSIZE].
- x_valid  out  1  x holds a complete, length-checked vector.
- x_ready  in  1  consumer accepts x.
- frame_err  out  1  one-cycle pulse on a frame-length error.
- word_cnt  out  CNT_W  samples stored so far in the current frame.

Behaviour:
- Reset (rst_n low, asynchronous): state=LOAD, word_cnt=0, x=all zeros, x_valid=0, s_ready=0, frame_err=0. s_ready rises at the first rising edge after rst_n deasserts.
- Accept handshake = s_valid & s_ready at a rising edge. Output handshake = x_valid & x_ready at a rising edge.
- States: LOAD, FULL, DRAIN.
- LOAD, s_ready=1. On accept, s_data is written to slot word_cnt.
  - word_cnt<N_input-1, s_last=0: word_cnt+1, stay in LOAD.
  - word_cnt<N_input-1, s_last=1 (short frame): frame_err pulses the next cycle, word_cnt=0, stay in LOAD. Partial slots keep their stale data and x_valid stays 0.
  - word_cnt==N_input-1, s_last=1: go to FULL. x_valid=1 and s_ready=0 from the next cycle; word_cnt=N_input.
  - word_cnt==N_input-1, s_last=0 (long frame): frame_err pulses, go to DRAIN, word_cnt=0.
- DRAIN, s_ready=1. Accepted samples are discarded and x is not written. On an accept with s_last=1, return to LOAD. No further frame_err pulses.
- FULL, s_ready=0, x_valid=1. x is frozen and ignores s_* activity. On output handshake: next cycle x_valid=0, s_ready=1, word_cnt=0, state=LOAD. This costs one bubble cycle.
- x is never cleared except by reset. After release it keeps the previous vector until slots are overwritten. The consumer samples x only while x_valid=1.
- Latency: last sample accepted at edge k gives x_valid=1 during the cycle after edge k. The encoder is combinational, so its outputs are valid in that same cycle.
- s_valid with s_ready=0 is legal. The sample is not consumed and the source must hold it.
- x_ready is ignored while x_valid=0.
- Mid-operation reset returns to the reset values immediately; any partial frame is lost.
- word_cnt never exceeds N_input.

Test Plan:
- Nominal frame: reset, then 9 samples 0x00010000..0x00090000 back-to-back, s_last on the 9th → x_valid=1 in the cycle after the 9th accept; x[0 +: 32]=0x00010000, x[256 +: 32]=0x00090000; frame_err=0; s_ready=0.
- Backpressure and hold: from FULL, keep x_ready=0 for 5 cycles while driving s_valid=1 → x stable, s_ready=0, no writes. Assert x_ready for 1 cycle → x_valid=0 and s_ready=1 the next cycle, word_cnt=0.
- Short frame: 4 samples with s_last on the 4th → one frame_err pulse, x_valid stays 0. A following correct 9-sample frame → x_valid=1 with the new data in all 9 slots.
- Long frame: 11 samples with s_last on the 11th → frame_err pulses after the 9th accept, samples 10–11 discarded, x_valid never set. A next valid frame loads correctly.
- Gapped input: 9 samples with s_valid toggling 1/0 each cycle → word_cnt increments only on accepts; x_valid asserts after the 9th accept; data order is preserved.
- Async reset mid-frame: drop rst_n after 5 accepts, between clock edges → word_cnt=0, x=0, x_valid=0, s_ready=0 immediately. After release, a full 9-sample frame completes normally.

Source files
------------

// File: rtl/encoder_input_loader_if.sv
// Stream-in / vector-out bundle between the sample source, the loader and the dense encoder.
interface encoder_input_loader_if #(
  parameter int N_input = 9,
  parameter int BITSIZE = 32,
  parameter int CNT_W   = $clog2(N_input) + 1
);
  logic signed [BITSIZE-1:0]         s_data;
  logic                              s_valid;
  logic                              s_last;
  logic                              s_ready;
  logic        [N_input*BITSIZE-1:0] x;
  logic                              x_valid;
  logic                              x_ready;
  logic                              frame_err;
  logic        [CNT_W-1:0]           word_cnt;

  modport slave (
    input  s_data, s_valid, s_last, x_ready,
    output s_ready, x, x_valid, frame_err, word_cnt
  );

  modport master (
    output s_data, s_valid, s_last, x_ready,
    input  s_ready, x, x_valid, frame_err, word_cnt
  );
endinterface

// File: rtl/encoder_input_loader.sv
// Serial-to-parallel loader: packs N_input samples into the encoder x vector and drops
// frames whose s_last position does not match N_input.
module encoder_input_loader #(
  parameter int N_input = 9,
  parameter int BITSIZE = 32,
  parameter int CNT_W   = $clog2(N_input) + 1
) (
  input logic                    clk,
  input logic                    rst_n,
  encoder_input_loader_if.slave  bus
);
  typedef enum logic [1:0] {LOAD, FULL, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_input - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_input);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
  logic [N_input*BITSIZE-1:0]  x_q, x_d;
  logic                        x_valid_q, x_valid_d;
  logic                        s_ready_q, s_ready_d;
  logic                        frame_err_q, frame_err_d;

  logic accept;
  logic out_hs;

  assign accept = bus.s_valid & s_ready_q;
  assign out_hs = x_valid_q & bus.x_ready;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
    s_ready_d   = s_ready_q;
    frame_err_d = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready_d = 1'b1;
        if (accept) begin
          for (int i = 0; i < N_input; i++) begin
            if (word_cnt_q == CNT_W'(i)) x_d[i*BITSIZE +: BITSIZE] = bus.s_data;
          end
          if (word_cnt_q == LAST_IDX) begin
            if (bus.s_last) begin
              state_d    = FULL;
              x_valid_d  = 1'b1;
              s_ready_d  = 1'b0;
              word_cnt_d = FULL_CNT;
            end else begin
              // Too long: discard the rest of this frame up to its s_last.
              state_d     = DRAIN;
              frame_err_d = 1'b1;
              word_cnt_d  = '0;
            end
          end else if (bus.s_last) begin
            frame_err_d = 1'b1;
            word_cnt_d  = '0;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (out_hs) begin
          state_d    = LOAD;
          x_valid_d  = 1'b0;
          s_ready_d  = 1'b1;
          word_cnt_d = '0;
        end
      end
      DRAIN: begin
        s_ready_d = 1'b1;
        if (accept && bus.s_last) state_d = LOAD;
      end
      default: begin
        state_d    = LOAD;
        word_cnt_d = '0;
        x_valid_d  = 1'b0;
        s_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      word_cnt_q  <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.x         = x_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.word_cnt  = word_cnt_q;
endmodule
